// File: rtl/vram_blit.sv
// vram_blit: copies a run of bytes from VIDEO_BUF into VRAM under register control and pulses done_irq on completion.
// Build option: define VRAM_BLIT_VSYNC_EN to hold each transfer until a falling edge of the registered v_sync.
module vram_blit #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [31:0]       cfg_data,
    output logic [31:0]       status_out,
    output logic [14:0]       buf_addr,
    input  logic [DATA_W-1:0] buf_data_out,
    output logic [14:0]       vram_addr,
    output logic [DATA_W-1:0] vram_data_in,
    output logic              vram_we,
    input  logic              v_sync,
    output logic              done_irq
);

`ifdef VRAM_BLIT_VSYNC_EN
    typedef enum logic [2:0] {IDLE, WAIT_VS, PRIME, COPY, DONE} state_t;
    localparam state_t FIRST = WAIT_VS;
`else
    typedef enum logic [2:0] {IDLE, PRIME, COPY, DONE} state_t;
    localparam state_t FIRST = PRIME;
`endif

    state_t      state, state_nxt;
    logic [14:0] src_base, dst_base, remaining, offs;
    logic        done_flag, aborted_flag;
    logic        base_wr, start_req, abort_req, busy;
    logic [14:0] len_in;
    logic        unused_in;

    assign base_wr   = cfg_we & ~cfg_sel;
    assign start_req = cfg_we & cfg_sel & cfg_data[15];
    assign abort_req = cfg_we & cfg_sel & cfg_data[16];
    assign len_in    = cfg_data[14:0];
    assign busy      = (state != IDLE);

`ifdef VRAM_BLIT_VSYNC_EN
    logic vs_p0, vs_p1, vs_fall;

    // v_sync input register and edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_p0 <= 1'b1;
            vs_p1 <= 1'b1;
        end else begin
            vs_p0 <= v_sync;
            vs_p1 <= vs_p0;
        end
    end

    assign vs_fall   = vs_p1 & ~vs_p0;
    assign unused_in = cfg_data[31];
`else
    assign unused_in = cfg_data[31] ^ v_sync;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_req && !abort_req)
                    state_nxt = (len_in == 15'd0) ? DONE : FIRST;
            end
`ifdef VRAM_BLIT_VSYNC_EN
            WAIT_VS: begin
                if (abort_req)
                    state_nxt = IDLE;
                else if (vs_fall)
                    state_nxt = PRIME;
            end
`endif
            PRIME: state_nxt = abort_req ? IDLE : COPY;
            COPY: begin
                if (abort_req)
                    state_nxt = IDLE;
                else if (remaining == 15'd1)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            src_base     <= '0;
            dst_base     <= '0;
            remaining    <= '0;
            offs         <= '0;
            done_flag    <= 1'b0;
            aborted_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            if (base_wr && !busy) begin
                src_base <= cfg_data[14:0];
                dst_base <= cfg_data[30:16];
            end
            if (state == IDLE && start_req) begin
                if (abort_req) begin
                    aborted_flag <= 1'b1;
                end else begin
                    remaining    <= len_in;
                    offs         <= '0;
                    done_flag    <= 1'b0;
                    aborted_flag <= 1'b0;
                end
            end
            if (state == COPY) begin
                remaining <= remaining - 15'd1;
                offs      <= offs + 15'd1;
            end
            // DONE is already signalling completion, so a late abort is not recorded there
            if (busy && state != DONE && abort_req)
                aborted_flag <= 1'b1;
            if (state_nxt == DONE)
                done_flag <= 1'b1;
        end
    end

    // The read address runs one beat ahead so each COPY beat finds its byte on buf_data_out
    always_comb begin
        buf_addr     = '0;
        vram_addr    = '0;
        vram_data_in = '0;
        vram_we      = 1'b0;
        case (state)
            PRIME: buf_addr = src_base;
            COPY: begin
                buf_addr     = src_base + offs + 15'd1;
                vram_addr    = dst_base + offs;
                vram_data_in = buf_data_out;
                vram_we      = ~rst;
            end
            default: ;
        endcase
    end

    assign done_irq   = (state == DONE) & ~rst;
    assign status_out = {busy, done_flag, aborted_flag, 14'b0, remaining};

endmodule

// File: tb/tb_vram_blit.sv
// Self-checking bench for vram_blit: random buffer contents and transfers checked against a simple copy model.
module tb_vram_blit;

`ifdef VRAM_BLIT_VSYNC_EN
    localparam int XLAT = 2;
`else
    localparam int XLAT = 0;
`endif

    logic        clk, rst, cfg_we, cfg_sel, vram_we, v_sync, done_irq;
    logic [31:0] cfg_data, status_out;
    logic [14:0] buf_addr, vram_addr;
    logic [7:0]  buf_data_out, vram_data_in;

    vram_blit #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .status_out(status_out), .buf_addr(buf_addr), .buf_data_out(buf_data_out),
        .vram_addr(vram_addr), .vram_data_in(vram_data_in), .vram_we(vram_we),
        .v_sync(v_sync), .done_irq(done_irq)
    );

    logic [7:0]  mem [0:32767];
    int          cyc = 0;
    int          n_checks = 0, n_fail = 0;
    int          wt[$], it[$];
    logic [14:0] wa[$], wb[$];
    logic [7:0]  wd[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;
    always @(posedge clk) buf_data_out <= mem[buf_addr];

    // A write or IRQ seen mid-cycle takes effect at the next rising edge
    always @(negedge clk) begin
        if (vram_we) begin
            wt.push_back(cyc + 1);
            wa.push_back(vram_addr);
            wd.push_back(vram_data_in);
            wb.push_back(buf_addr);
        end
        if (done_irq) it.push_back(cyc + 1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        wt.delete(); wa.delete(); wd.delete(); wb.delete(); it.delete();
    endtask

    task automatic cfg_write(input logic sel, input logic [31:0] d, output int t);
        cfg_we = 1'b1; cfg_sel = sel; cfg_data = d;
        @(posedge clk);
        #1;
        t = cyc;
        cfg_we = 1'b0; cfg_data = '0;
    endtask

    task automatic set_base(input logic [14:0] src, input logic [14:0] dst);
        int t;
        cfg_write(1'b0, {1'b0, dst, 1'b0, src}, t);
    endtask

    task automatic start(input logic [14:0] len, output int t);
        cfg_write(1'b1, {16'h0, 1'b1, len}, t);
`ifdef VRAM_BLIT_VSYNC_EN
        v_sync = 1'b0;
        step(1);
        v_sync = 1'b1;
`endif
    endtask

    // Model: beat k copies buf[src+k] to vram[dst+k] at T+2+k, done_irq at T+L+2
    task automatic expect_copy(input string tag, input logic [14:0] src, input logic [14:0] dst,
                               input int len, input int t0);
        logic [14:0] ea, es, eb;
        while (cyc < t0 + len + XLAT + 6) step(1);
        check({tag, " nwr"}, wt.size(), len);
        for (int k = 0; k < len && k < wt.size(); k++) begin
            ea = dst + 15'(k);
            es = src + 15'(k);
            eb = es + 15'd1;
            check($sformatf("%s t%0d", tag, k), wt[k], t0 + 2 + XLAT + k);
            check($sformatf("%s addr%0d", tag, k), wa[k], ea);
            check($sformatf("%s data%0d", tag, k), wd[k], mem[es]);
            check($sformatf("%s baddr%0d", tag, k), wb[k], eb);
        end
        check({tag, " nirq"}, it.size(), 1);
        if (it.size() > 0) check({tag, " tirq"}, it[0], t0 + len + 2 + XLAT);
        check({tag, " status"}, status_out, 32'h4000_0000);
    endtask

    task automatic run_copy(input string tag, input logic [14:0] src, input logic [14:0] dst, input int len);
        int t;
        clear_logs();
        set_base(src, dst);
        start(15'(len), t);
        expect_copy(tag, src, dst, len, t);
    endtask

    initial begin
        int t, ta, tb2, nw, x;
        logic [14:0] s, d;
        for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
        rst = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_data = '0; v_sync = 1'b1;
        step(3);
        check("rst status", status_out, 32'h0);
        check("rst we", {31'b0, vram_we}, 32'h0);
        check("rst irq", {31'b0, done_irq}, 32'h0);
        check("rst baddr", buf_addr, 32'h0);
        check("rst vaddr", vram_addr, 32'h0);
        check("rst vdata", vram_data_in, 32'h0);
        rst = 1'b0;
        step(2);

        run_copy("basic", 15'h0010, 15'h0100, 4);
        run_copy("wrap", 15'h7FFE, 15'h7FFF, 3);
        for (int i = 0; i < 3; i++)
            run_copy($sformatf("rand%0d", i), 15'($urandom), 15'($urandom), $urandom_range(1, 24));

        clear_logs();
        start(15'd0, t);
        step(4);
        check("zero nwr", wt.size(), 0);
        check("zero nirq", it.size(), 1);
        if (it.size() > 0) check("zero tirq", it[0], t + 1);
        check("zero status", status_out, 32'h4000_0000);

        clear_logs();
        cfg_write(1'b1, 32'h0001_0000, t);
        step(4);
        check("idleabort nwr", wt.size(), 0);
        check("idleabort status", status_out, 32'h4000_0000);

        s = 15'($urandom); d = 15'($urandom);
        clear_logs();
        set_base(s, d);
        start(15'd30, t);
        while (cyc < t + 10) step(1);
        cfg_write(1'b1, 32'h0000_8005, ta);
        cfg_write(1'b0, 32'h1234_4321, tb2);
        check("busy bit", status_out[31], 1'b1);
        check("busy remain", status_out[14:0], 30 - (tb2 - (t + 1 + XLAT)));
        expect_copy("busy", s, d, 30, t);

        clear_logs();
        set_base(15'($urandom), 15'($urandom));
        start(15'd100, t);
        while (cyc < t + 11 + XLAT) step(1);
        cfg_write(1'b1, 32'h0001_0000, ta);
        nw = ta - t - 1 - XLAT;
        step(1);
        check("abort we", {31'b0, vram_we}, 32'h0);
        while (cyc < ta + 10) step(1);
        check("abort nwr", wt.size(), nw);
        if (wt.size() > 0) check("abort last", wt[wt.size() - 1], ta);
        check("abort nirq", it.size(), 0);
        check("abort status", status_out, 32'h2000_0000 | 32'(100 - nw));

        clear_logs();
        cfg_write(1'b1, 32'h0001_8005, t);
        step(8);
        check("startabort nwr", wt.size(), 0);
        check("startabort busy", status_out[31], 1'b0);
        check("startabort flag", status_out[29], 1'b1);

        clear_logs();
        set_base(15'($urandom), 15'($urandom));
        start(15'd20, t);
        while (cyc < t + 6 + XLAT) step(1);
        rst = 1'b1;
        #1;
        check("midrst we now", {31'b0, vram_we}, 32'h0);
        step(1);
        check("midrst status", status_out, 32'h0);
        check("midrst baddr", buf_addr, 32'h0);
        check("midrst vaddr", vram_addr, 32'h0);
        rst = 1'b0;
        step(30);
        check("midrst nwr", wt.size(), 5);
        check("midrst nirq", it.size(), 0);
        run_copy("after rst", 15'($urandom), 15'($urandom), $urandom_range(1, 16));

`ifdef VRAM_BLIT_VSYNC_EN
        clear_logs();
        set_base(15'h0200, 15'h0300);
        cfg_write(1'b1, 32'h0000_8004, t);
        step(50);
        check("vs hold nwr", wt.size(), 0);
        check("vs hold busy", status_out[31], 1'b1);
        x = cyc;
        v_sync = 1'b0;
        step(1);
        v_sync = 1'b1;
        while (cyc < x + 12) step(1);
        check("vs nwr", wt.size(), 4);
        if (wt.size() > 0) check("vs first", wt[0], x + 4);
        check("vs nirq", it.size(), 1);

        clear_logs();
        cfg_write(1'b1, 32'h0000_8004, t);
        step(5);
        cfg_write(1'b1, 32'h0001_0000, ta);
        v_sync = 1'b0;
        step(1);
        v_sync = 1'b1;
        step(8);
        check("vs abort nwr", wt.size(), 0);
        check("vs abort busy", status_out[31], 1'b0);
        check("vs abort flag", status_out[29], 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_blit.md
VRAM_BLIT -- requirements
Module: vram_blit

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all logic on the rising edge.
REQ-002 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-003 SHALL have port cfg_we, input, 1, register write strobe from the bus decoder.
REQ-004 SHALL have port cfg_sel, input, 1, register select: 0 = BASE, 1 = CTRL.
REQ-005 SHALL have port cfg_data, input, 32, register write data.
REQ-006 SHALL have port status_out, output, 32, status word for bus readback.
REQ-007 SHALL have port buf_addr, output, 15, source VIDEO_BUF read address.
REQ-008 SHALL have port buf_data_out, input, 8, VIDEO_BUF read data, valid 1 cycle after buf_addr.
REQ-009 SHALL have port vram_addr, output, 15, VRAM port-A write address.
REQ-010 SHALL have port vram_data_in, output, 8, VRAM write data.
REQ-011 SHALL have port vram_we, output, 1, VRAM write enable.
REQ-012 SHALL have port v_sync, input, 1, active-low VGA vertical sync, same clock domain.
REQ-013 SHALL have port done_irq, output, 1, one-cycle completion pulse.

Function
REQ-014 BASE write SHALL latch src_base = cfg_data[14:0] and dst_base = cfg_data[30:16]; ignored while busy.
REQ-015 CTRL write SHALL use cfg_data[14:0] = length L, bit 15 = start, bit 16 = abort.
REQ-016 FSM states SHALL be IDLE, WAIT_VS, PRIME, COPY, DONE.
REQ-017 Start in IDLE SHALL latch L, clear the done and aborted flags, and enter WAIT_VS (macro defined) or PRIME (macro undefined) on the next cycle.
REQ-018 Start with L = 0 SHALL go from IDLE directly to DONE with no VRAM writes.
REQ-019 PRIME SHALL drive buf_addr = src_base for one cycle with vram_we = 0.
REQ-020 In COPY beat k (k = 0..L-1), outputs SHALL be: vram_we = 1, vram_addr = dst_base+k, vram_data_in = buf_data_out, buf_addr = src_base+k+1.
REQ-021 All address sums SHALL be 15 bits, wrapping modulo 32768.
REQ-022 After beat L-1 the FSM SHALL enter DONE: done_irq = 1 and done flag set for one cycle, then return to IDLE.
REQ-023 Latency SHALL be as follows, with start written at edge T:
  - first write at cycle T+2 (macro undefined);
  - last write at cycle T+L+1;
  - done_irq at cycle T+L+2.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 Start while busy SHALL be ignored.
REQ-026 Abort while busy SHALL:
  - set vram_we = 0 from the next cycle;
  - set the aborted flag;
  - return to IDLE with no done_irq.
REQ-027 Start and abort in the same IDLE write SHALL resolve to abort: no transfer, aborted flag set.
REQ-028 Abort in IDLE with start = 0 SHALL have no effect.
REQ-029 status_out SHALL be {busy, done_flag, aborted_flag, 14'b0, remaining[14:0]}; remaining = L minus beats written.
REQ-030 vram_we SHALL be 0 in every state other than COPY.

Reset
REQ-031 rst SHALL force all of the following:
  - state = IDLE, src_base = dst_base = 0, L = 0, remaining = 0;
  - all flags = 0;
  - vram_we = 0, done_irq = 0, buf_addr = 0, vram_addr = 0, vram_data_in = 0, status_out = 0.
REQ-032 rst mid-transfer SHALL stop writes in the same cycle, with no done_irq.

Configuration
REQ-033 Macro VRAM_BLIT_VSYNC_EN defined: WAIT_VS SHALL be held until a 1->0 transition of registered v_sync is detected, then PRIME follows on the next cycle; abort SHALL be honoured in WAIT_VS.
REQ-034 Macro VRAM_BLIT_VSYNC_EN undefined: WAIT_VS SHALL not exist, v_sync SHALL be ignored, and REQ-023 timing SHALL apply.

Verification
REQ-035 Basic copy: BASE = 0x0100_0010, CTRL = 0x0000_8004 -> 4 writes vram_addr 0x0100..0x0103 carrying buf[0x10..0x13]; done_irq at T+6; status_out = 0x4000_0000.
REQ-036 Wrap-around: src 0x7FFE, dst 0x7FFF, L = 3 -> buf_addr sequence 0x7FFE, 0x7FFF, 0x0000; vram_addr sequence 0x7FFF, 0x0000, 0x0001.
REQ-037 Abort: L = 100, abort written after beat 10 -> vram_we low from the next cycle; status_out[29] = 1; remaining = 89 or 90 matching the beats written; no done_irq.
REQ-038 Zero length and restart: CTRL = 0x0000_8000 -> done_irq at T+1, no writes; start while busy ignored (remaining unchanged, no restart).
REQ-039 Reset mid-transfer at beat 5 of 20 -> next cycle vram_we = 0 and status_out = 0; a new start then runs normally.
REQ-040 With VRAM_BLIT_VSYNC_EN: start with v_sync held 1 for 50 cycles -> no writes; v_sync falls -> first write 3 cycles after the registered falling edge.
